// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// ALU operations and datapath mux selects.
package multicycle_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_BC   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_NOP  = 4'hD;
  localparam logic [3:0] OP_ILL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_OFF  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_HALT    = 4'd11,
    S_ILLEGAL = 4'd12,
    S_FAULT   = 4'd13
  } state_t;

  // States that hold mem_req and therefore wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    logic r;
    case (s)
      S_FETCH, S_MEM_RD, S_MEM_WR: r = 1'b1;
      default:                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_p_if.sv
// Control bus between the multicycle control unit (master) and the
// datapath/memory side (slave).
interface multicycle_ctrl_p_if #(
  parameter int OP_W   = 4,
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 16
);
  logic [OP_W-1:0]   op;
  logic              zero;
  logic              carry;
  logic              mem_ready;
  logic              mem_req;
  logic              pcen;
  logic              memwrite;
  logic              irwrite;
  logic              regwrite;
  logic              alusrca;
  logic              iord;
  logic              memtoreg;
  logic              regdst;
  logic [1:0]        alusrcb;
  logic [1:0]        pcsrc;
  logic [ALUC_W-1:0] alucontrol;
  logic              halted;
  logic              fault;
  logic [CNT_W-1:0]  instret;

  modport master (
    input  op, zero, carry, mem_ready,
    output mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord,
           memtoreg, regdst, alusrcb, pcsrc, alucontrol, halted, fault, instret
  );

  modport slave (
    output op, zero, carry, mem_ready,
    input  mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord,
           memtoreg, regdst, alusrcb, pcsrc, alucontrol, halted, fault, instret
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory wait cycles in one state and flags the cycle on
// which the wait budget runs out. MEM_TIMEOUT of 0 disables the flag.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic wait_cycle,
  output logic timeout
);
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : {CW{1'b0}};
  localparam logic ENABLED = (MEM_TIMEOUT > 0);

  logic [CW-1:0] count_r;

  // Saturating wait counter, zeroed whenever the FSM leaves its state.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_r <= {CW{1'b0}};
    end else if (wait_cycle && (count_r != LIMIT)) begin
      count_r <= count_r + CW'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign timeout = ENABLED && wait_cycle && (count_r == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_p.sv
// Multicycle processor control unit: FSM sequencing with a memory
// ready handshake, timeout fault, halt/illegal handling and instret counter.
module multicycle_ctrl_p
  import multicycle_pkg::*;
#(
  parameter int OP_W          = 4,
  parameter int ALUC_W        = 3,
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_TIMEOUT   = 64,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_p_if.master bus
);

  state_t            state_r;
  state_t            next_state_s;
  logic              is_rtype_r;
  logic [CNT_W-1:0]  instret_r;
  logic              ready_s;
  logic              wait_s;
  logic              timeout_s;
  logic              state_change_s;
  logic              retire_s;
  logic              branch_taken_s;
  logic              mem_req_s;
  logic              pcen_s;
  logic              memwrite_s;
  logic              irwrite_s;
  logic              regwrite_s;
  logic              alusrca_s;
  logic              iord_s;
  logic              memtoreg_s;
  logic              regdst_s;
  logic [1:0]        alusrcb_s;
  logic [1:0]        pcsrc_s;
  logic [ALUC_W-1:0] alucontrol_s;
  logic              halted_s;
  logic              fault_s;

  function automatic state_t decode_target(input logic [OP_W-1:0] o);
    state_t t;
    case (o)
      OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_AND),
      OP_W'(OP_OR),  OP_W'(OP_XOR), OP_W'(OP_SLT):  t = S_EXEC_R;
      OP_W'(OP_ADDI):                               t = S_EXEC_I;
      OP_W'(OP_LW), OP_W'(OP_SW):                   t = S_MEM_ADR;
      OP_W'(OP_BEQ), OP_W'(OP_BNE), OP_W'(OP_BC):   t = S_BRANCH;
      OP_W'(OP_JMP):                                t = S_JUMP;
      OP_W'(OP_NOP):                                t = S_FETCH;
      OP_W'(OP_HALT):                               t = S_HALT;
      default:                                      t = S_ILLEGAL;
    endcase
    return t;
  endfunction

  assign ready_s        = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
  assign wait_s         = is_mem_state(state_r) && !ready_s;
  assign state_change_s = (next_state_s != state_r);

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_change_s),
    .wait_cycle(wait_s),
    .timeout   (timeout_s)
  );

  // Branch condition evaluated on the ALU flags of the current cycle.
  always_comb begin
    branch_taken_s = 1'b0;
    case (bus.op)
      OP_W'(OP_BEQ): branch_taken_s = bus.zero;
      OP_W'(OP_BNE): branch_taken_s = !bus.zero;
      OP_W'(OP_BC):  branch_taken_s = bus.carry;
      default:       branch_taken_s = 1'b0;
    endcase
  end

  // State register plus the R-type flag that ALU_WB needs after op is gone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_FETCH;
      is_rtype_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE) begin
        is_rtype_r <= (decode_target(bus.op) == S_EXEC_R);
      end else begin
        is_rtype_r <= is_rtype_r;
      end
    end
  end

  // Next-state and control-bus decode.
  always_comb begin
    next_state_s = state_r;
    retire_s     = 1'b0;
    mem_req_s    = 1'b0;
    pcen_s       = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    iord_s       = 1'b0;
    memtoreg_s   = 1'b0;
    regdst_s     = 1'b0;
    alusrcb_s    = SRCB_REGB;
    pcsrc_s      = PCSRC_ALU;
    alucontrol_s = ALUC_W'(ALU_ADD);
    halted_s     = 1'b0;
    fault_s      = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        alusrcb_s = SRCB_ONE;
        if (timeout_s) begin
          next_state_s = S_FAULT;
        end else if (ready_s) begin
          irwrite_s    = 1'b1;
          pcen_s       = 1'b1;
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb_s    = SRCB_OFF;
        next_state_s = decode_target(bus.op);
        retire_s     = (decode_target(bus.op) == S_FETCH);
      end
      S_EXEC_R: begin
        alusrca_s    = 1'b1;
        alucontrol_s = ALUC_W'(bus.op[2:0]);
        next_state_s = S_ALU_WB;
      end
      S_EXEC_I: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_IMM;
        next_state_s = S_ALU_WB;
      end
      S_ALU_WB: begin
        regwrite_s   = 1'b1;
        regdst_s     = is_rtype_r;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_ADR: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_IMM;
        next_state_s = (bus.op == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        if (timeout_s) begin
          next_state_s = S_FAULT;
        end else if (ready_s) begin
          next_state_s = S_MEM_WB;
        end else begin
          next_state_s = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        regwrite_s   = 1'b1;
        memtoreg_s   = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_s  = 1'b1;
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
        if (timeout_s) begin
          next_state_s = S_FAULT;
        end else if (ready_s) begin
          retire_s     = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_BRANCH: begin
        alusrca_s    = 1'b1;
        alucontrol_s = ALUC_W'(ALU_SUB);
        pcsrc_s      = PCSRC_ALUOUT;
        pcen_s       = branch_taken_s;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_s      = PCSRC_JUMP;
        pcen_s       = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_HALT: begin
        halted_s = 1'b1;
      end
      S_ILLEGAL, S_FAULT: begin
        halted_s = 1'b1;
        fault_s  = 1'b1;
      end
      default: begin
        halted_s     = 1'b1;
        fault_s      = 1'b1;
        next_state_s = S_FAULT;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      instret_r <= instret_r + CNT_W'(1'b1);
    end else begin
      instret_r <= instret_r;
    end
  end

  // Reset forces the whole bus low immediately, before the state register updates.
  assign bus.mem_req    = mem_req_s  & ~reset;
  assign bus.pcen       = pcen_s     & ~reset;
  assign bus.memwrite   = memwrite_s & ~reset;
  assign bus.irwrite    = irwrite_s  & ~reset;
  assign bus.regwrite   = regwrite_s & ~reset;
  assign bus.alusrca    = alusrca_s  & ~reset;
  assign bus.iord       = iord_s     & ~reset;
  assign bus.memtoreg   = memtoreg_s & ~reset;
  assign bus.regdst     = regdst_s   & ~reset;
  assign bus.alusrcb    = reset ? 2'b00 : alusrcb_s;
  assign bus.pcsrc      = reset ? 2'b00 : pcsrc_s;
  assign bus.alucontrol = reset ? {ALUC_W{1'b0}} : alucontrol_s;
  assign bus.halted     = halted_s   & ~reset;
  assign bus.fault      = fault_s    & ~reset;
  assign bus.instret    = reset ? {CNT_W{1'b0}} : instret_r;

endmodule
